// File: rtl/ep2_cmd_parser_pkg.sv
// Shared state encoding, framing constants and C0 field helpers for the EP2 command parser.
package ep2_cmd_parser_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    CC   = 3'd3,
    PL   = 3'd4,
    S0   = 3'd5
  } ep2_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h7F;
  localparam int         CC_BYTES  = 5;
  localparam int         HDR_BYTES = 8;

  localparam int C0_PTT_BIT  = 0;
  localparam int C0_ADDR_LO  = 1;
  localparam int C0_ADDR_HI  = 6;
  localparam int C0_RESP_BIT = 7;

  function automatic logic [5:0] c0_addr(input logic [7:0] c0);
    return c0[C0_ADDR_HI:C0_ADDR_LO];
  endfunction

  function automatic logic c0_ptt(input logic [7:0] c0);
    return c0[C0_PTT_BIT];
  endfunction

  function automatic logic c0_resp(input logic [7:0] c0);
    return c0[C0_RESP_BIT];
  endfunction

endpackage

// File: rtl/ep2_cmd_parser_sync_counter.sv
// Sync-loss reporting: one-cycle error pulse plus a saturating loss counter.
module ep2_cmd_parser_sync_counter
  import ep2_cmd_parser_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                err_evt,
  output logic                sync_err,
  output logic [ERRCNT_W-1:0] sync_err_cnt
);

  localparam logic [ERRCNT_W-1:0] CNT_MAX = {ERRCNT_W{1'b1}};
  localparam logic [ERRCNT_W-1:0] CNT_ONE = ERRCNT_W'(1);

  // Pulse and counter registers; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err     <= 1'b0;
      sync_err_cnt <= {ERRCNT_W{1'b0}};
    end else begin
      sync_err <= err_evt;
      if (err_evt && (sync_err_cnt != CNT_MAX)) begin
        sync_err_cnt <= sync_err_cnt + CNT_ONE;
      end else begin
        sync_err_cnt <= sync_err_cnt;
      end
    end
  end

endmodule

// File: rtl/ep2_cmd_parser.sv
// EP2 host-to-radio frame parser: locks on 7F7F7F sync, decodes C0..C4 into a
// command strobe and forwards the payload bytes to the TX sample path.
module ep2_cmd_parser
  import ep2_cmd_parser_pkg::*;
#(
  parameter int FRAME_BYTES = 512,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic [5:0]          cmd_addr,
  output logic [31:0]         cmd_data,
  output logic                cmd_rqst,
  output logic                cmd_requires_resp,
  output logic                cmd_ptt,
  output logic [7:0]          pl_data,
  output logic                pl_valid,
  output logic                pl_first,
  output logic                sync_err,
  output logic [ERRCNT_W-1:0] sync_err_cnt,
  output logic                in_sync
);

  localparam int                PCNT_W  = $clog2(FRAME_BYTES - HDR_BYTES);
  localparam logic [PCNT_W-1:0] PL_LAST = PCNT_W'(FRAME_BYTES - HDR_BYTES - 1);
  localparam logic [2:0]        CC_LAST = 3'(CC_BYTES - 1);

  ep2_state_t        state_r, state_nxt_s;
  logic [2:0]        idx_r, idx_nxt_s;
  logic [PCNT_W-1:0] pcnt_r, pcnt_nxt_s;
  logic [7:0]        shadow_r [CC_BYTES];
  logic              is_sync_s;
  logic              err_s;
  logic              cc_cap_s;
  logic              c4_done_s;
  logic              pl_take_s;
  logic              cmd_pend_r;

  assign is_sync_s = (in_data == SYNC_BYTE);

  // Next-state decode; only accepted bytes move the framer.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    pcnt_nxt_s  = pcnt_r;
    err_s       = 1'b0;
    cc_cap_s    = 1'b0;
    c4_done_s   = 1'b0;
    pl_take_s   = 1'b0;
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (in_sof && is_sync_s) state_nxt_s = S1;
          else                     state_nxt_s = HUNT;
        end
        S1, S2, CC, PL: begin
          if (in_sof) begin
            // Premature frame start: abort, then judge this byte as a hunt byte.
            err_s = 1'b1;
            if (is_sync_s) state_nxt_s = S1;
            else           state_nxt_s = HUNT;
          end else begin
            case (state_r)
              S1: begin
                if (is_sync_s) begin
                  state_nxt_s = S2;
                end else begin
                  state_nxt_s = HUNT;
                  err_s       = 1'b1;
                end
              end
              S2: begin
                if (is_sync_s) begin
                  state_nxt_s = CC;
                  idx_nxt_s   = 3'd0;
                end else begin
                  state_nxt_s = HUNT;
                  err_s       = 1'b1;
                end
              end
              CC: begin
                cc_cap_s = 1'b1;
                if (idx_r == CC_LAST) begin
                  state_nxt_s = PL;
                  pcnt_nxt_s  = {PCNT_W{1'b0}};
                  c4_done_s   = 1'b1;
                end else begin
                  idx_nxt_s = idx_r + 3'd1;
                end
              end
              PL: begin
                pl_take_s = 1'b1;
                if (pcnt_r == PL_LAST) state_nxt_s = S0;
                else                   pcnt_nxt_s  = pcnt_r + PCNT_W'(1);
              end
              default: state_nxt_s = HUNT;
            endcase
          end
        end
        S0: begin
          if (in_sof && is_sync_s) begin
            state_nxt_s = S1;
          end else begin
            state_nxt_s = HUNT;
            err_s       = 1'b1;
          end
        end
        default: state_nxt_s = HUNT;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Framer state and byte counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HUNT;
      idx_r   <= 3'd0;
      pcnt_r  <= {PCNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      pcnt_r  <= pcnt_nxt_s;
    end
  end

  // C&C shadow capture, indexed by the position within the C&C field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CC_BYTES; i++) shadow_r[i] <= 8'h00;
    end else if (cc_cap_s) begin
      shadow_r[idx_r] <= in_data;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Command interface: strobe one cycle after C4, fields hold between commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_pend_r        <= 1'b0;
      cmd_rqst          <= 1'b0;
      cmd_addr          <= 6'd0;
      cmd_data          <= 32'd0;
      cmd_requires_resp <= 1'b0;
      cmd_ptt           <= 1'b0;
    end else begin
      cmd_pend_r <= c4_done_s;
      cmd_rqst   <= cmd_pend_r;
      if (cmd_pend_r) begin
        cmd_addr          <= c0_addr(shadow_r[0]);
        cmd_data          <= {shadow_r[1], shadow_r[2], shadow_r[3], shadow_r[4]};
        cmd_requires_resp <= c0_resp(shadow_r[0]);
        cmd_ptt           <= c0_ptt(shadow_r[0]);
      end else begin
        cmd_addr          <= cmd_addr;
        cmd_data          <= cmd_data;
        cmd_requires_resp <= cmd_requires_resp;
        cmd_ptt           <= cmd_ptt;
      end
    end
  end

  // Payload forwarding with one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl_data  <= 8'h00;
      pl_valid <= 1'b0;
      pl_first <= 1'b0;
    end else begin
      pl_valid <= pl_take_s;
      pl_first <= pl_take_s && (pcnt_r == {PCNT_W{1'b0}});
      if (pl_take_s) pl_data <= in_data;
      else           pl_data <= pl_data;
    end
  end

  // Lock indicator: set by a completed C&C field, dropped by any sync loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sync <= 1'b0;
    end else if (err_s) begin
      in_sync <= 1'b0;
    end else if (c4_done_s) begin
      in_sync <= 1'b1;
    end else begin
      in_sync <= in_sync;
    end
  end

  ep2_cmd_parser_sync_counter #(
    .ERRCNT_W (ERRCNT_W)
  ) u_sync_counter (
    .clk          (clk),
    .rst          (rst),
    .err_evt      (err_s),
    .sync_err     (sync_err),
    .sync_err_cnt (sync_err_cnt)
  );

endmodule

// File: doc/ep2_cmd_parser.md
Name: ep2_cmd_parser

Overview:
- Host-to-radio frame parser for the Protocol 1 EP2 stream.
- Consumes the byte stream of 512-byte EP2 frames already stripped of Ethernet/UDP/EP headers.
- Locates the 0x7F7F7F sync and decodes the C0..C4 command bytes into the cmd_addr/cmd_data/cmd_rqst/cmd_requires_resp/cmd_ptt interface consumed by control; the block is the initiator side of that interface.
- Forwards the 504 payload bytes (TX I/Q and audio) to the TX sample path and reports sync errors.

Parameters:
- FRAME_BYTES, 512: bytes per EP2 frame, including 3 sync and 5 C&C bytes.
- ERRCNT_W, 8: width of the saturating sync-error counter.

Ports:
- clk  in  1  system clock (2.5 MHz control domain)
- rst  in  1  asynchronous active-high reset
- in_data  in  8  EP2 byte
- in_valid  in  1  in_data valid this cycle
- in_sof  in  1  qualifies in_valid; marks the first byte of a 512-byte frame
- cmd_addr  out  6  C0[6:1]
- cmd_data  out  32  {C1,C2,C3,C4}
- cmd_rqst  out  1  one-cycle strobe; command fields valid
- cmd_requires_resp  out  1  C0[7]
- cmd_ptt  out  1  C0[0] (MOX)
- pl_data  out  8  payload byte
- pl_valid  out  1  payload byte strobe
- pl_first  out  1  with pl_valid; first payload byte of a frame
- sync_err  out  1  one-cycle pulse on each sync loss
- sync_err_cnt  out  ERRCNT_W  saturating count of sync losses
- in_sync  out  1  high while framing is locked

Behaviour:
- Reset values: all outputs 0; state = HUNT.
- Only cycles with in_valid=1 advance the FSM. Cycles with in_valid=0 hold all state; strobes deassert.
- HUNT:
  - in_valid & in_sof & byte==0x7F -> S1.
  - All other bytes are dropped silently (no repeated error count).
- S1: byte==0x7F -> S2; else -> HUNT with error.
- S2: byte==0x7F -> CC with idx=0; else -> HUNT with error.
- CC:
  - Bytes are captured into shadow registers C0..C4 by idx; idx increments per byte.
  - On the idx==4 byte: state -> PL with pcnt=0.
  - On the next clk: cmd_rqst=1 for exactly one cycle, and cmd_addr/cmd_data/cmd_ptt/cmd_requires_resp update from the shadows in that same cycle.
  - Output fields hold until the next command; they are not cleared.
  - Latency: C4 accepted at edge N -> cmd_rqst high in cycle N+1.
- PL:
  - Each byte: pl_data=in_data and pl_valid=1, registered with 1-cycle latency. pl_first=1 when pcnt==0.
  - pcnt counts to FRAME_BYTES-9. On the last byte -> S0 (expect next frame).
- S0 (locked, awaiting next frame):
  - in_sof & 0x7F -> S1.
  - Any byte without in_sof, or with in_sof but not 0x7F -> HUNT with error.
- Error: sync_err pulses 1 cycle; sync_err_cnt increments and saturates at all-ones (never wraps); in_sync -> 0.
- in_sync=1 from the first successful C4 capture until the next error.
- in_sof asserted in S1, S2, CC or PL (premature frame start):
  - Abort the frame and count one error.
  - That byte is re-evaluated as a HUNT byte: if 0x7F, go to S1 in the same cycle.
  - A partial C&C never issues cmd_rqst.
- in_sof on any byte other than the first of a frame in HUNT is not an error.
- Reset mid-frame: immediate return to HUNT, all outputs 0, counter cleared, no strobe generated.

Decomposition:
- Shared package (e.g. ep2_pkg):
  - State enum {HUNT,S1,S2,CC,PL,S0}.
  - SYNC_BYTE=8'h7F, CC_BYTES=5, HDR_BYTES=8.
  - Bit positions of C0 fields (PTT=0, ADDR=6:1, RESP=7).
- One natural sub-module: ep2_sync_counter, the saturating error counter plus sync_err pulse.
- FSM, byte counters and output registers stay in the top.

Test Plan:
- Valid frame: sof+7F7F7F, C0=0x93, C1..C4=0x12,0x34,0x56,0x78, then 504 bytes -> one cmd_rqst with cmd_addr=0x09, cmd_ptt=1, cmd_requires_resp=1, cmd_data=0x12345678. 504 pl_valid strobes, pl_first on byte 0 only. in_sync=1, sync_err_cnt=0.
- Back-to-back frames with in_valid gapped randomly -> two cmd_rqst strobes, 1008 payload strobes, no errors, fields match the second frame after its strobe.
- Corrupt 2nd sync byte (0x7E) -> sync_err pulse, cnt=1, in_sync=0, no cmd_rqst, no pl_valid. The following good frame re-locks and issues its command.
- in_sof with 0x7F at payload byte 100 -> error cnt+1, frame aborted after 100 payload bytes. The new frame starting at that byte decodes correctly.
- 300 consecutive sync errors with ERRCNT_W=8 -> sync_err_cnt sticks at 255; sync_err still pulses each time.
- Assert rst after the C2 byte -> all outputs 0 asynchronously, no cmd_rqst. The next full frame decodes normally.
